wakeup_cam_rdy: RTL and testbench

- Parametrised next-generation issue-queue wakeup CAM. Holds one source-operand tag per IQ entry, plus a per-entry valid bit and a sticky ready bit.
- Result-tag broadcasts match entries and set the ready bit. Deallocation, flush and partition power-down are supported, the last through a scrub state machine.
- Sits between dispatch (write ports) and select (ready vector) in the issue queue. Replaces the plain tag-match CAM.

---
 rtl/wakeup_cam_rdy_if.sv | 35 +++
 rtl/wakeup_cam_rdy.sv | 171 +++++++++++++++++
 tb/tb_wakeup_cam_rdy.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wakeup_cam_rdy_if.sv
// Dispatch/broadcast/select bundle of the issue-queue wakeup CAM.
// master drives dispatch writes, broadcasts and control; slave is the CAM.
interface wakeup_cam_rdy_if #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned INDEX     = 5,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned NUM_WR    = 4,
    parameter int unsigned NUM_RD    = 4,
    parameter int unsigned NUM_PARTS = 4
);
    logic [NUM_WR-1:0]       wr_en_i;
    logic [NUM_WR*INDEX-1:0] wr_addr_i;
    logic [NUM_WR*WIDTH-1:0] wr_tag_i;
    logic [NUM_WR-1:0]       wr_rdy_i;
    logic [NUM_RD-1:0]       bcast_valid_i;
    logic [NUM_RD*WIDTH-1:0] bcast_tag_i;
    logic [DEPTH-1:0]        free_i;
    logic                    flush_i;
    logic [NUM_PARTS-1:0]    part_active_i;
    logic [DEPTH-1:0]        wakeup_o;
    logic [DEPTH-1:0]        ready_o;
    logic                    cam_ready_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_tag_i, wr_rdy_i,
        output bcast_valid_i, bcast_tag_i, free_i, flush_i, part_active_i,
        input  wakeup_o, ready_o, cam_ready_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_tag_i, wr_rdy_i,
        input  bcast_valid_i, bcast_tag_i, free_i, flush_i, part_active_i,
        output wakeup_o, ready_o, cam_ready_o
    );
endinterface

// File: rtl/wakeup_cam_rdy.sv
// Issue-queue wakeup CAM: one source tag per entry with valid and sticky ready
// bits, broadcast wakeup, deallocation, flush and partition power-down scrub.
module wakeup_cam_rdy #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned INDEX     = 5,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned NUM_WR    = 4,
    parameter int unsigned NUM_RD    = 4,
    parameter int unsigned NUM_PARTS = 4,
    parameter int unsigned PART_LOG  = 2
) (
    input  logic            clk,
    input  logic            reset,
    wakeup_cam_rdy_if.slave bus
);
    localparam int unsigned PART_SZ = DEPTH / NUM_PARTS;
    localparam logic [PART_LOG-1:0] LAST_PART = PART_LOG'(NUM_PARTS - 1);

    typedef enum logic {IDLE, SCRUB} state_e;

    state_e               state_q, state_d;
    logic [PART_LOG-1:0]  cnt_q, cnt_d;
    logic [NUM_PARTS-1:0] pend_q, pend_d;
    logic [NUM_PARTS-1:0] part_q, part_d;
    logic [NUM_PARTS-1:0] deact;
    logic [WIDTH-1:0]     tag_q [DEPTH];
    logic [WIDTH-1:0]     tag_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d, rdy_q, rdy_d, ready_q, ready_d;
    logic                 cam_ready_q, cam_ready_d;

    logic [DEPTH-1:0]     entry_act, hit, wakeup, scrub_clr;
    logic [DEPTH-1:0]     wr_hit, wr_rdy_sel;
    logic [WIDTH-1:0]     wr_tag_sel [DEPTH];
    logic                 bypass, accept;

    function automatic logic [PART_LOG-1:0] part_of(input int idx);
        return PART_LOG'(idx / PART_SZ);
    endfunction

    // Partition enable per entry and the zero-latency tag match on current contents
    always_comb begin
        entry_act = '0;
        hit       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_act[i] = bus.part_active_i[part_of(i)];
            for (int k = 0; k < NUM_RD; k++) begin
                if (bus.bcast_valid_i[k] && (tag_q[i] == bus.bcast_tag_i[k*WIDTH +: WIDTH]))
                    hit[i] = 1'b1;
            end
        end
        hit    = hit & valid_q & entry_act;
        wakeup = hit & ~rdy_q;
    end

    assign bus.wakeup_o    = wakeup;
    assign bus.ready_o     = ready_q;
    assign bus.cam_ready_o = cam_ready_q;

    // Write decode: later ports overwrite earlier ones, so the highest index wins
    always_comb begin
        wr_hit     = '0;
        wr_rdy_sel = '0;
        bypass     = 1'b0;
        accept     = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr_tag_sel[i] = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            bypass = 1'b0;
            for (int j = 0; j < NUM_RD; j++) begin
                if (bus.bcast_valid_i[j] &&
                    (bus.bcast_tag_i[j*WIDTH +: WIDTH] == bus.wr_tag_i[k*WIDTH +: WIDTH]))
                    bypass = 1'b1;
            end
            accept = bus.wr_en_i[k] && (state_q == IDLE) && !bus.flush_i &&
                     bus.part_active_i[part_of(32'(bus.wr_addr_i[k*INDEX +: INDEX]))];
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && (bus.wr_addr_i[k*INDEX +: INDEX] == INDEX'(i))) begin
                    wr_hit[i]     = 1'b1;
                    wr_tag_sel[i] = bus.wr_tag_i[k*WIDTH +: WIDTH];
                    wr_rdy_sel[i] = bus.wr_rdy_i[k] | bypass;
                end
            end
        end
    end

    // Per-entry next state, applied lowest priority first so later steps override
    always_comb begin
        scrub_clr = '0;
        valid_d   = valid_q;
        rdy_d     = rdy_q | wakeup;
        for (int i = 0; i < DEPTH; i++) begin
            tag_d[i]     = tag_q[i];
            scrub_clr[i] = (state_q == SCRUB) && pend_q[cnt_q] && (part_of(i) == cnt_q);
            if (bus.free_i[i]) begin
                valid_d[i] = 1'b0;
                rdy_d[i]   = 1'b0;
            end
            if (wr_hit[i]) begin
                tag_d[i]   = wr_tag_sel[i];
                valid_d[i] = 1'b1;
                rdy_d[i]   = wr_rdy_sel[i];
            end
            if (scrub_clr[i] || bus.flush_i) begin
                valid_d[i] = 1'b0;
                rdy_d[i]   = 1'b0;
            end
        end
        ready_d = valid_d & rdy_d & entry_act;
    end

    // Scrub sequencer: one partition per cycle, extra passes while work remains
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        part_d  = bus.part_active_i;
        deact   = part_q & ~bus.part_active_i;
        case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    pend_d = '0;
                end else if (deact != '0) begin
                    state_d = SCRUB;
                    pend_d  = deact;
                    cnt_d   = '0;
                end
            end
            SCRUB: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                    pend_d  = '0;
                    cnt_d   = '0;
                end else begin
                    pend_d[cnt_q] = 1'b0;
                    pend_d        = pend_d | deact;
                    if (cnt_q == LAST_PART) begin
                        cnt_d = '0;
                        if (pend_d == '0) state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + PART_LOG'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cam_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            part_q      <= '1;
            valid_q     <= '0;
            rdy_q       <= '0;
            ready_q     <= '0;
            cam_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            part_q      <= part_d;
            valid_q     <= valid_d;
            rdy_q       <= rdy_d;
            ready_q     <= ready_d;
            cam_ready_q <= cam_ready_d;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
        end
    end
endmodule

// File: tb/tb_wakeup_cam_rdy.sv
// Directed plus randomized bench for wakeup_cam_rdy, checked against a
// cycle-level behavioural model of the CAM held in plain arrays.
module tb_wakeup_cam_rdy;
    logic clk;
    logic reset;

    wakeup_cam_rdy_if ifc ();

    wakeup_cam_rdy dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus as seen by the model
    logic [3:0]  wr_en, wr_rdy, bv;
    logic [4:0]  wr_addr [4];
    logic [6:0]  wr_tag  [4];
    logic [6:0]  bt      [4];
    logic [31:0] free;
    logic        flush;
    logic [3:0]  act;

    // Behavioural model
    int          m_tag [32];
    logic [31:0] m_valid, m_rdy, m_ready;
    logic        m_camrdy, m_scrub;
    int          m_cnt;
    logic [3:0]  m_pend, m_partq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        wr_en = '0; wr_rdy = '0; bv = '0; free = '0; flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_addr[k] = '0; wr_tag[k] = '0; bt[k] = '0;
        end
    endtask

    task automatic drive();
        ifc.wr_en_i       = wr_en;
        ifc.wr_rdy_i      = wr_rdy;
        ifc.bcast_valid_i = bv;
        ifc.free_i        = free;
        ifc.flush_i       = flush;
        ifc.part_active_i = act;
        for (int k = 0; k < 4; k++) begin
            ifc.wr_addr_i[k*5 +: 5]   = wr_addr[k];
            ifc.wr_tag_i[k*7 +: 7]    = wr_tag[k];
            ifc.bcast_tag_i[k*7 +: 7] = bt[k];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tag[i] = 0;
        m_valid = '0; m_rdy = '0; m_ready = '0;
        m_camrdy = 1'b1; m_scrub = 1'b0; m_cnt = 0; m_pend = '0; m_partq = 4'hF;
    endtask

    function automatic logic bcast_has(input int tag);
        for (int k = 0; k < 4; k++)
            if (bv[k] && int'(bt[k]) == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_wakeup();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++)
            w[i] = m_valid[i] && !m_rdy[i] && act[i/8] && bcast_has(m_tag[i]);
        return w;
    endfunction

    task automatic model_step();
        logic [31:0] nv, nr;
        logic [3:0]  deact;
        int a;
        deact = m_partq & ~act;
        nv = m_valid & ~free;
        nr = (m_rdy | model_wakeup()) & ~free;
        if (!m_scrub && !flush) begin
            for (int k = 0; k < 4; k++) begin
                a = int'(wr_addr[k]);
                if (wr_en[k] && act[a/8]) begin
                    m_tag[a] = int'(wr_tag[k]);
                    nv[a] = 1'b1;
                    nr[a] = wr_rdy[k] | bcast_has(int'(wr_tag[k]));
                end
            end
        end
        if (m_scrub && m_pend[m_cnt])
            for (int i = m_cnt*8; i < m_cnt*8 + 8; i++) begin
                nv[i] = 1'b0; nr[i] = 1'b0;
            end
        if (flush) begin
            nv = '0; nr = '0;
            m_scrub = 1'b0; m_pend = '0; m_cnt = 0;
        end else if (!m_scrub) begin
            if (deact != 0) begin
                m_scrub = 1'b1; m_pend = deact; m_cnt = 0;
            end
        end else begin
            m_pend = (m_pend & ~(4'b0001 << m_cnt)) | deact;
            if (m_cnt == 3) begin
                m_cnt = 0;
                if (m_pend == 0) m_scrub = 1'b0;
            end else begin
                m_cnt++;
            end
        end
        m_valid = nv; m_rdy = nr; m_partq = act;
        for (int i = 0; i < 32; i++) m_ready[i] = nv[i] & nr[i] & act[i/8];
        m_camrdy = !m_scrub;
    endtask

    task automatic check_model();
        chk("model_wakeup", ifc.wakeup_o, model_wakeup());
        chk("model_ready", ifc.ready_o, m_ready);
        chk("model_cam_ready", 32'(ifc.cam_ready_o), 32'(m_camrdy));
    endtask

    task automatic settle();
        drive();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        act = 4'hF;
        clear_in();
        drive();
        model_reset();
        @(negedge clk);
        chk("rst_ready", ifc.ready_o, 32'h0);
        chk("rst_cam_ready", 32'(ifc.cam_ready_o), 32'h1);
        chk("rst_wakeup", ifc.wakeup_o, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_model();
        advance();

        // Write then broadcast; a repeated broadcast must not wake again
        clear_in(); wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_tag[0] = 7'h15;
        settle(); advance();
        clear_in(); bv[2] = 1'b1; bt[2] = 7'h15;
        settle(); chk("wake3", 32'(ifc.wakeup_o[3]), 32'h1); advance();
        settle(); chk("ready3", 32'(ifc.ready_o[3]), 32'h1);
        chk("rewake3", 32'(ifc.wakeup_o[3]), 32'h0); advance();

        // Same-cycle write and broadcast
        clear_in(); wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_tag[0] = 7'h22;
        bv[0] = 1'b1; bt[0] = 7'h22;
        settle(); advance();
        clear_in(); settle(); chk("bypass5", 32'(ifc.ready_o[5]), 32'h1); advance();

        // Two ports to one entry: port 3 wins
        clear_in(); wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_tag[1] = 7'h01;
        wr_en[3] = 1'b1; wr_addr[3] = 5'd7; wr_tag[3] = 7'h02;
        settle(); advance();
        clear_in(); bv[1] = 1'b1; bt[1] = 7'h01;
        settle(); chk("coll_lose", 32'(ifc.wakeup_o[7]), 32'h0); advance();
        clear_in(); bv[3] = 1'b1; bt[3] = 7'h02;
        settle(); chk("coll_win", 32'(ifc.wakeup_o[7]), 32'h1); advance();

        // Fill every entry ready
        for (int c = 0; c < 8; c++) begin
            clear_in();
            for (int k = 0; k < 4; k++) begin
                wr_en[k] = 1'b1; wr_rdy[k] = 1'b1;
                wr_addr[k] = 5'(c*4 + k); wr_tag[k] = 7'(c*4 + k);
            end
            settle(); advance();
        end
        clear_in(); settle(); chk("fill_all", ifc.ready_o, 32'hFFFF_FFFF); advance();

        // Power down partitions 2 and 3: one pass of four cycles
        act = 4'b0011; settle(); advance();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (ifc.cam_ready_o) break;
            if (c == 0) begin
                chk("pd_hi_off", 32'(ifc.ready_o[31:16]), 32'h0);
                chk("pd_lo_on", 32'(ifc.ready_o[15:0]), 32'hFFFF);
            end
            n++;
            advance();
        end
        chk("scrub_len1", 32'(n), 32'd4);
        advance();
        act = 4'hF; settle(); advance();
        settle();
        chk("react_hi", 32'(ifc.ready_o[31:16]), 32'h0);
        chk("react_lo", 32'(ifc.ready_o[15:0]), 32'hFFFF);
        chk("react_cam", 32'(ifc.cam_ready_o), 32'h1);
        advance();

        // Second deactivation mid-scrub forces another pass
        act = 4'b0011; settle(); advance();
        n = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) act = 4'b0001;
            settle();
            if (ifc.cam_ready_o) break;
            n++;
            advance();
        end
        chk("scrub_len2", 32'(n), 32'd8);
        chk("scrub2_ready", ifc.ready_o, 32'h0000_00FF);
        advance();

        // Flush during a scrub
        act = 4'hF; settle(); advance();
        act = 4'b1110; settle(); advance();
        settle(); chk("pre_flush_cam", 32'(ifc.cam_ready_o), 32'h0); advance();
        flush = 1'b1; settle(); advance();
        flush = 1'b0; settle();
        chk("flush_ready", ifc.ready_o, 32'h0);
        chk("flush_cam", 32'(ifc.cam_ready_o), 32'h1);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            clear_in();
            for (int k = 0; k < 4; k++) begin
                wr_en[k]   = ($urandom_range(0, 2) == 0);
                wr_rdy[k]  = ($urandom_range(0, 3) == 0);
                wr_addr[k] = 5'($urandom_range(0, 31));
                wr_tag[k]  = 7'($urandom_range(0, 7));
                bv[k]      = ($urandom_range(0, 2) == 0);
                bt[k]      = 7'($urandom_range(0, 7));
            end
            free  = $urandom() & $urandom() & $urandom();
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 14) == 0) act = 4'($urandom_range(0, 15));
            settle(); advance();
        end

        // Asynchronous reset with live entries
        clear_in(); act = 4'hF; flush = 1'b1; settle(); advance();
        clear_in();
        for (int k = 0; k < 4; k++) begin
            wr_en[k] = 1'b1; wr_rdy[k] = 1'b1; wr_addr[k] = 5'(k); wr_tag[k] = 7'(k);
        end
        settle(); advance();
        clear_in(); settle();
        chk("pre_rst_ready", 32'(ifc.ready_o[3:0]), 32'hF);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ready", ifc.ready_o, 32'h0);
        chk("async_rst_cam", 32'(ifc.cam_ready_o), 32'h1);
        chk("async_rst_wake", ifc.wakeup_o, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_model();
        advance();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
